// File: rtl/mod11_wrap_monitor.sv
// Monitor for a mod-11 loadable counter. It counts 10->0 wraps, emits a divided tick
// and latches sticky range/sequence faults.
module mod11_wrap_monitor #(
  parameter int unsigned WRAP_W   = 8,
  parameter int unsigned WRAP_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        cnt_in,
  input  logic              load_en_in,
  input  logic              err_clr,
  input  logic              cnt_clr,
  output logic              wrap_pulse,
  output logic              div_tick,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              err_range,
  output logic              err_seq,
  output logic [3:0]        bad_val,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    StUnprimed = 2'd0,
    StTrack    = 2'd1,
    StFault    = 2'd2
  } state_e;

  localparam logic [3:0]        MaxCnt  = 4'd10;
  localparam logic [WRAP_W-1:0] DivLast = WRAP_W'(WRAP_DIV - 1);

  state_e            r_state;
  state_e            w_state_next;
  logic [3:0]        r_prev_cnt;
  logic              r_prev_load;
  logic [WRAP_W-1:0] r_wrap_count;
  logic [WRAP_W-1:0] r_div;
  logic              r_wrap_pulse;
  logic              r_div_tick;
  logic              r_err_range;
  logic              r_err_seq;
  logic [3:0]        r_bad_val;

  logic [3:0]        w_exp;
  logic              w_range_bad;
  logic              w_set_range;
  logic              w_set_seq;
  logic              w_wrap;

  assign w_exp       = (r_prev_cnt == MaxCnt) ? 4'd0 : r_prev_cnt + 4'd1;
  assign w_range_bad = (cnt_in > MaxCnt);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StUnprimed;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (err_clr) begin
      w_state_next = StUnprimed;
    end else begin
      unique case (r_state)
        StUnprimed: w_state_next = w_set_range ? StFault : StTrack;
        StTrack: begin
          if (w_set_range || w_set_seq) begin
            w_state_next = StFault;
          end
        end
        StFault: w_state_next = StFault;
        default: w_state_next = StUnprimed;
      endcase
    end
  end

  // Per-state event decode; the priming edge only range-checks, and a load
  // on the previous edge exempts this sample from the sequence check.
  always_comb begin
    w_set_range = 1'b0;
    w_set_seq   = 1'b0;
    w_wrap      = 1'b0;
    unique case (r_state)
      StUnprimed: w_set_range = w_range_bad;
      StTrack: begin
        w_set_range = w_range_bad;
        w_set_seq   = !r_prev_load && (cnt_in != w_exp);
        w_wrap      = !r_prev_load && (r_prev_cnt == MaxCnt) && (cnt_in == 4'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_cnt   <= 4'd0;
      r_prev_load  <= 1'b0;
      r_err_range  <= 1'b0;
      r_err_seq    <= 1'b0;
      r_bad_val    <= 4'd0;
      r_wrap_pulse <= 1'b0;
      r_div_tick   <= 1'b0;
      r_wrap_count <= '0;
      r_div        <= '0;
    end else begin
      r_prev_cnt   <= cnt_in;
      r_prev_load  <= load_en_in;
      r_wrap_pulse <= w_wrap;
      r_div_tick   <= 1'b0;

      if (err_clr) begin
        r_err_range <= 1'b0;
        r_err_seq   <= 1'b0;
        r_bad_val   <= 4'd0;
      end else begin
        if (w_set_range) r_err_range <= 1'b1;
        if (w_set_seq)   r_err_seq   <= 1'b1;
        // Only the first fault since the last clear is recorded.
        if ((w_set_range || w_set_seq) && !r_err_range && !r_err_seq) begin
          r_bad_val <= cnt_in;
        end
      end

      if (cnt_clr) begin
        r_wrap_count <= '0;
        r_div        <= '0;
      end else if (w_wrap) begin
        if (r_wrap_count != '1) begin
          r_wrap_count <= r_wrap_count + WRAP_W'(1);
        end
        if (r_div == DivLast) begin
          r_div      <= '0;
          r_div_tick <= 1'b1;
        end else begin
          r_div <= r_div + WRAP_W'(1);
        end
      end
    end
  end

  assign wrap_pulse = r_wrap_pulse;
  assign div_tick   = r_div_tick;
  assign wrap_count = r_wrap_count;
  assign err_range  = r_err_range;
  assign err_seq    = r_err_seq;
  assign bad_val    = r_bad_val;
  assign state_o    = r_state;

endmodule

// File: tb/tb_mod11_wrap_monitor.sv
// Directed vector bench for mod11_wrap_monitor; a second instance with a 2-bit
// wrap counter shares the stimulus to exercise saturation.
module tb_mod11_wrap_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cnt_in;
  logic       load_en_in;
  logic       err_clr;
  logic       cnt_clr;

  logic       wrap_pulse, div_tick, err_range, err_seq;
  logic [7:0] wrap_count;
  logic [3:0] bad_val;
  logic [1:0] state_o;

  logic       d2_wrap_pulse, d2_div_tick, d2_err_range, d2_err_seq;
  logic [1:0] d2_wrap_count;
  logic [3:0] d2_bad_val;
  logic [1:0] d2_state_o;

  always #5 clk = ~clk;

  mod11_wrap_monitor #(.WRAP_W(8), .WRAP_DIV(4)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_in     (cnt_in),
    .load_en_in (load_en_in),
    .err_clr    (err_clr),
    .cnt_clr    (cnt_clr),
    .wrap_pulse (wrap_pulse),
    .div_tick   (div_tick),
    .wrap_count (wrap_count),
    .err_range  (err_range),
    .err_seq    (err_seq),
    .bad_val    (bad_val),
    .state_o    (state_o)
  );

  mod11_wrap_monitor #(.WRAP_W(2), .WRAP_DIV(2)) u_dut2 (
    .clk        (clk),
    .rst        (rst),
    .cnt_in     (cnt_in),
    .load_en_in (load_en_in),
    .err_clr    (err_clr),
    .cnt_clr    (cnt_clr),
    .wrap_pulse (d2_wrap_pulse),
    .div_tick   (d2_div_tick),
    .wrap_count (d2_wrap_count),
    .err_range  (d2_err_range),
    .err_seq    (d2_err_seq),
    .bad_val    (d2_bad_val),
    .state_o    (d2_state_o)
  );

  typedef struct {
    logic       rst;
    logic [3:0] cnt;
    logic       ld;
    logic       ec;
    logic       cc;
    logic       wrap;
    logic       tick;
    logic [7:0] wc;
    logic [1:0] wc2;
    logic       er;
    logic       es;
    logic [3:0] bv;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic [3:0] c, input logic ld, input logic ec,
                     input logic cc, input logic w, input logic t, input int wc,
                     input logic er, input logic es, input logic [3:0] bv,
                     input logic [1:0] st);
    vec_t v;
    v.rst = r; v.cnt = c; v.ld = ld; v.ec = ec; v.cc = cc;
    v.wrap = w; v.tick = t; v.wc = 8'(wc);
    v.wc2 = (wc > 3) ? 2'd3 : 2'(wc);
    v.er = er; v.es = es; v.bv = bv; v.st = st;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic [3:0] c, input logic ld, input logic ec,
                      input logic cc);
    rst = r; cnt_in = c; load_en_in = ld; err_clr = ec; cnt_clr = cc;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [19:0] got;
    logic [19:0] exp;

    rst = 1'b1; cnt_in = 4'd0; load_en_in = 1'b0; err_clr = 1'b0; cnt_clr = 1'b0;

    // Reset
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Free run: four wraps, tick on the fourth
    for (int k = 0; k <= 44; k++)
      add(0, 4'(k % 11), 0, 0, 0, (k > 0) && (k % 11 == 0), k == 44, k / 11, 0, 0, 0, 1);
    // Load 7 at count 3, then count through to a wrap
    add(0, 1, 0, 0, 0, 0, 0, 4, 0, 0, 0, 1);
    add(0, 2, 0, 0, 0, 0, 0, 4, 0, 0, 0, 1);
    add(0, 3, 1, 0, 0, 0, 0, 4, 0, 0, 0, 1);
    add(0, 7, 0, 0, 0, 0, 0, 4, 0, 0, 0, 1);
    add(0, 8, 0, 0, 0, 0, 0, 4, 0, 0, 0, 1);
    add(0, 9, 0, 0, 0, 0, 0, 4, 0, 0, 0, 1);
    add(0, 10, 0, 0, 0, 0, 0, 4, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0, 5, 0, 0, 0, 1);
    // Load 4 while at 10 (no wrap), then load 10 and step to 0 (wrap)
    for (int k = 1; k <= 9; k++) add(0, 4'(k), 0, 0, 0, 0, 0, 5, 0, 0, 0, 1);
    add(0, 10, 1, 0, 0, 0, 0, 5, 0, 0, 0, 1);
    add(0, 4, 0, 0, 0, 0, 0, 5, 0, 0, 0, 1);
    add(0, 5, 1, 0, 0, 0, 0, 5, 0, 0, 0, 1);
    add(0, 10, 0, 0, 0, 0, 0, 5, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0, 6, 0, 0, 0, 1);
    // Sequence fault 5 -> 8; wraps suppressed in FAULT; err_clr re-primes
    for (int k = 1; k <= 5; k++) add(0, 4'(k), 0, 0, 0, 0, 0, 6, 0, 0, 0, 1);
    add(0, 8, 0, 0, 0, 0, 0, 6, 0, 1, 8, 2);
    add(0, 9, 0, 0, 0, 0, 0, 6, 0, 1, 8, 2);
    add(0, 10, 0, 0, 0, 0, 0, 6, 0, 1, 8, 2);
    add(0, 0, 0, 0, 0, 0, 0, 6, 0, 1, 8, 2);
    add(0, 1, 0, 1, 0, 0, 0, 6, 0, 0, 0, 0);
    add(0, 2, 0, 0, 0, 0, 0, 6, 0, 0, 0, 1);
    add(0, 3, 0, 0, 0, 0, 0, 6, 0, 0, 0, 1);
    // Load 12 -> range fault; clear wins over a coincident bad value; double fault
    add(0, 4, 1, 0, 0, 0, 0, 6, 0, 0, 0, 1);
    add(0, 12, 0, 0, 0, 0, 0, 6, 1, 0, 12, 2);
    add(0, 13, 0, 1, 0, 0, 0, 6, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 6, 0, 0, 0, 1);
    add(0, 12, 0, 0, 0, 0, 0, 6, 1, 1, 12, 2);
    add(0, 0, 0, 1, 0, 0, 0, 6, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 6, 0, 0, 0, 1);
    for (int k = 2; k <= 10; k++) add(0, 4'(k), 0, 0, 0, 0, 0, 6, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0, 7, 0, 0, 0, 1);
    // cnt_clr on the wrap that would have ticked
    for (int k = 1; k <= 10; k++) add(0, 4'(k), 0, 0, 0, 0, 0, 7, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    // Five more wraps: 2-bit instance saturates at 3
    for (int k = 1; k <= 55; k++)
      add(0, 4'(k % 11), 0, 0, 0, k % 11 == 0, k == 44, k / 11, 0, 0, 0, 1);
    // Reset mid-count overrides clears; then prime with 0
    for (int k = 1; k <= 5; k++) add(0, 4'(k), 0, 0, 0, 0, 0, 5, 0, 0, 0, 1);
    add(1, 6, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].cnt, vecs[i].ld, vecs[i].ec, vecs[i].cc);
      got = {wrap_pulse, div_tick, wrap_count, d2_wrap_count, err_range, err_seq,
             bad_val, state_o};
      exp = {vecs[i].wrap, vecs[i].tick, vecs[i].wc, vecs[i].wc2, vecs[i].er, vecs[i].es,
             vecs[i].bv, vecs[i].st};
      n_vec++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL vec %0d: got wrap=%b tick=%b wc=%0d wc2=%0d er=%b es=%b bv=%0d st=%0d, expected wrap=%b tick=%b wc=%0d wc2=%0d er=%b es=%b bv=%0d st=%0d",
                 i, got[19], got[18], got[17:10], got[9:8], got[7], got[6], got[5:2],
                 got[1:0], exp[19], exp[18], exp[17:10], exp[9:8], exp[7], exp[6],
                 exp[5:2], exp[1:0]);
      end
    end

    // Range fault straight from UNPRIMED, FAULT holds bad_val, then prime at 10
    step(1, 0, 0, 0, 0);
    check("rst_state", 16'(state_o), 16'd0);
    step(0, 15, 0, 0, 0);
    check("unprimed_range", {12'd0, err_range, err_seq, state_o}, {12'd0, 1'b1, 1'b0, 2'd2});
    check("unprimed_badval", 16'(bad_val), 16'd15);
    step(0, 3, 0, 0, 0);
    check("fault_hold", {10'd0, bad_val, state_o}, {10'd0, 4'd15, 2'd2});
    step(0, 0, 0, 1, 0);
    check("clr_flags", {10'd0, err_range, err_seq, bad_val}, 16'd0);
    check("clr_state", 16'(state_o), 16'd0);
    step(0, 10, 0, 0, 0);
    check("prime_at_10", {14'd0, wrap_pulse, state_o[0]}, {14'd0, 1'b0, 1'b1});
    step(0, 0, 0, 0, 0);
    check("wrap_after_prime", {6'd0, wrap_pulse, wrap_count, state_o[0]},
          {6'd0, 1'b1, 8'd1, 1'b1});
    step(0, 1, 0, 0, 0);
    check("wrap_one_cycle", 16'(wrap_pulse), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
